// File: rtl/pixel_to_m_axis_packer.sv
// pixel_to_m_axis_packer
//
// Packs a stream of 24-bit RGB pixels into 32-bit AXI4-Stream master words.
// Four pixels become three words with no gaps. Bytes are little-endian and
// continuous: P0b0 P0b1 P0b2 P1b0 ... fill word bits [7:0], [15:8], ...
// When the packet ends on a pixel that does not complete a word, the
// leftover bytes are flushed as one zero-padded word marked with TLAST.
//
// Optional feature macro: PIXEL_PACK_TKEEP_EN
//   When defined, the m_axis_tkeep port exists. Full words carry 4'b1111.
//   Flush words carry 4'b0111, 4'b0011 or 4'b0001 for 3, 2 or 1 residue bytes.
//   When undefined, there is no tkeep port. Padding bytes are zero, and the
//   consumer infers the length from the pixel count.
//
// Ports:
//   clk            sole clock, rising edge
//   rst            synchronous, active-high reset
//   pixel_in       24-bit pixel, byte0 at [7:0]
//   pixel_valid    upstream pixel valid
//   pixel_ready    packer accepts pixel_in this cycle
//   pixel_last     final pixel of the packet (qualified by pixel_valid)
//   m_axis_tdata   packed 32-bit word
//   m_axis_tvalid  word valid
//   m_axis_tready  downstream ready
//   m_axis_tlast   final word of the packet
//   m_axis_tkeep   byte enables (only with PIXEL_PACK_TKEEP_EN)
//
// Parameters C_M_AXIS_TDATA_WIDTH and PIXEL_WIDTH exist for interface
// documentation only; the packing datapath supports only 32 and 24.

module pixel_to_m_axis_packer #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int PIXEL_WIDTH          = 24
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [PIXEL_WIDTH-1:0]          pixel_in,
    input  logic                            pixel_valid,
    output logic                            pixel_ready,
    input  logic                            pixel_last,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast
`ifdef PIXEL_PACK_TKEEP_EN
    ,
    output logic [3:0]                      m_axis_tkeep
`endif
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [1:0]  phase;
    logic [1:0]  phase_next;
    logic [23:0] residue;
    logic [23:0] residue_next;
    logic [31:0] tdata_next;
    logic        tvalid_next;
    logic        tlast_next;
`ifdef PIXEL_PACK_TKEEP_EN
    logic [3:0]  tkeep_next;
`endif

    logic free;
    logic accept;

    // The output stage can take a new word when it is empty or its word is
    // leaving this cycle. pixel_ready depends combinationally on tready.
    assign free        = !m_axis_tvalid || m_axis_tready;
    assign pixel_ready = free && (state == RUN);
    assign accept      = pixel_valid && pixel_ready;

    // Next-state and output-register logic.
    // The residue keeps its valid bytes in the low end with zeros above.
    // This lets a flush word be formed by zero-extending the residue.
    always_comb begin
        state_next   = state;
        phase_next   = phase;
        residue_next = residue;
        tdata_next   = m_axis_tdata;
        tvalid_next  = m_axis_tvalid;
        tlast_next   = m_axis_tlast;
`ifdef PIXEL_PACK_TKEEP_EN
        tkeep_next   = m_axis_tkeep;
`endif

        // A free output stage without a new load ends up empty.
        if (free) begin
            tvalid_next = 1'b0;
            tlast_next  = 1'b0;
        end

        case (state)
            RUN: begin
                if (accept) begin
                    phase_next = phase + 2'd1;
                    case (phase)
                        2'd0: begin
                            residue_next = pixel_in;
                        end
                        2'd1: begin
                            tdata_next   = {pixel_in[7:0], residue};
                            residue_next = {8'h00, pixel_in[23:8]};
                            tvalid_next  = 1'b1;
                            tlast_next   = 1'b0;
`ifdef PIXEL_PACK_TKEEP_EN
                            tkeep_next   = 4'b1111;
`endif
                        end
                        2'd2: begin
                            tdata_next   = {pixel_in[15:0], residue[15:0]};
                            residue_next = {16'h0000, pixel_in[23:16]};
                            tvalid_next  = 1'b1;
                            tlast_next   = 1'b0;
`ifdef PIXEL_PACK_TKEEP_EN
                            tkeep_next   = 4'b1111;
`endif
                        end
                        default: begin
                            tdata_next   = {pixel_in, residue[7:0]};
                            residue_next = 24'h000000;
                            tvalid_next  = 1'b1;
                            tlast_next   = pixel_last;
`ifdef PIXEL_PACK_TKEEP_EN
                            tkeep_next   = 4'b1111;
`endif
                        end
                    endcase
                    // A last pixel outside phase 3 leaves bytes that must be flushed.
                    if (pixel_last && (phase != 2'd3)) begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                // The phase here has already advanced past the last pixel.
                // Phase 1, 2 or 3 therefore means 3, 2 or 1 residue bytes.
                if (free) begin
                    tdata_next   = {8'h00, residue};
                    tvalid_next  = 1'b1;
                    tlast_next   = 1'b1;
`ifdef PIXEL_PACK_TKEEP_EN
                    case (phase)
                        2'd1:    tkeep_next = 4'b0111;
                        2'd2:    tkeep_next = 4'b0011;
                        default: tkeep_next = 4'b0001;
                    endcase
`endif
                    residue_next = 24'h000000;
                    phase_next   = 2'd0;
                    state_next   = RUN;
                end
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    // Reset discards any partial residue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RUN;
            phase         <= 2'd0;
            residue       <= 24'h000000;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
`ifdef PIXEL_PACK_TKEEP_EN
            m_axis_tkeep  <= 4'b0000;
`endif
        end else begin
            state         <= state_next;
            phase         <= phase_next;
            residue       <= residue_next;
            m_axis_tdata  <= tdata_next;
            m_axis_tvalid <= tvalid_next;
            m_axis_tlast  <= tlast_next;
`ifdef PIXEL_PACK_TKEEP_EN
            m_axis_tkeep  <= tkeep_next;
`endif
        end
    end

endmodule

// File: tb/tb_pixel_to_m_axis_packer.sv
// tb_pixel_to_m_axis_packer
//
// Self-checking bench for pixel_to_m_axis_packer.
// The reference model treats the stream as a plain byte queue. Each accepted
// pixel pushes three bytes. Every four bytes form a word. A packet end pads
// any remaining bytes into one final word.
// A negedge monitor compares every transferred word against the model.

module tb_pixel_to_m_axis_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] pixel_in;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        pixel_last;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
`ifdef PIXEL_PACK_TKEEP_EN
    logic [3:0]  m_axis_tkeep;
`endif

    always #5 clk = ~clk;

    pixel_to_m_axis_packer dut (
        .clk           (clk),
        .rst           (rst),
        .pixel_in      (pixel_in),
        .pixel_valid   (pixel_valid),
        .pixel_ready   (pixel_ready),
        .pixel_last    (pixel_last),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast)
`ifdef PIXEL_PACK_TKEEP_EN
        ,
        .m_axis_tkeep  (m_axis_tkeep)
`endif
    );

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  keep;
    } word_t;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [7:0]  byte_q[$];
    word_t       exp_q[$];
    logic [31:0] got_data[$];
    logic        got_last[$];
    int          mphase = 0;
    bit          prev_p0 = 1'b0;
    bit          prev_flush = 1'b0;
    bit          stall_prev = 1'b0;
    logic [31:0] stall_data;
    logic        stall_last;
    int          tready_mode = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Model: build the expected words from the byte stream of one accepted pixel.
    task automatic modelPixel(input logic [23:0] p, input logic last);
        word_t w;
        int    n;
        for (int i = 0; i < 3; i++) byte_q.push_back(p[8*i +: 8]);
        while (byte_q.size() >= 4) begin
            w.data = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
            repeat (4) void'(byte_q.pop_front());
            w.last = last && (byte_q.size() == 0);
            w.keep = 4'b1111;
            exp_q.push_back(w);
        end
        if (last && byte_q.size() > 0) begin
            n = byte_q.size();
            w.data = 32'h0;
            for (int i = 0; i < n; i++) w.data[8*i +: 8] = byte_q[i];
            w.last = 1'b1;
            w.keep = 4'((1 << n) - 1);
            exp_q.push_back(w);
            byte_q.delete();
            prev_flush = 1'b1;
        end
        mphase = last ? 0 : (mphase + 1) % 4;
    endtask

    // Per-cycle monitor: checks output transfers, stalls and ready rules.
    always @(negedge clk) begin
        word_t e;
        if (rst) begin
            byte_q.delete();
            exp_q.delete();
            mphase     = 0;
            prev_p0    = 1'b0;
            prev_flush = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (prev_p0) checkOutput("tvalid_after_phase0", {31'b0, m_axis_tvalid}, 32'd0);
            if (prev_flush) checkOutput("pready_in_flush", {31'b0, pixel_ready}, 32'd0);
            if (stall_prev) begin
                checkOutput("stall_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
                checkOutput("stall_tdata", m_axis_tdata, stall_data);
                checkOutput("stall_tlast", {31'b0, m_axis_tlast}, {31'b0, stall_last});
            end
            stall_prev = 1'b0;
            if (m_axis_tvalid && !m_axis_tready) begin
                checkOutput("pready_when_stalled", {31'b0, pixel_ready}, 32'd0);
                stall_prev = 1'b1;
                stall_data = m_axis_tdata;
                stall_last = m_axis_tlast;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_data.push_back(m_axis_tdata);
                got_last.push_back(m_axis_tlast);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_word: got %h want none", m_axis_tdata);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("word_data", m_axis_tdata, e.data);
                    checkOutput("word_last", {31'b0, m_axis_tlast}, {31'b0, e.last});
`ifdef PIXEL_PACK_TKEEP_EN
                    checkOutput("word_keep", {28'b0, m_axis_tkeep}, {28'b0, e.keep});
`endif
                end
            end
            prev_p0    = 1'b0;
            prev_flush = 1'b0;
            if (pixel_valid && pixel_ready) begin
                if (mphase == 0) prev_p0 = 1'b1;
                modelPixel(pixel_in, pixel_last);
            end
        end
    end

    // Downstream ready generator (mode 2 leaves tready to the main sequence).
    always @(posedge clk) begin
        #1;
        if (tready_mode == 0) m_axis_tready = 1'b1;
        else if (tready_mode == 1) m_axis_tready = ($urandom_range(0, 9) < 7);
    end

    // Present one pixel and hold it until accepted (bounded wait).
    task automatic applyStimulus(input logic [23:0] p, input logic last, input int gap, output int waited);
        bit done = 1'b0;
        waited = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        pixel_valid = 1'b1;
        pixel_in    = p;
        pixel_last  = last;
        while (!done) begin
            @(negedge clk);
            if (pixel_ready) done = 1'b1;
            else if (waited++ > 500) begin
                total++;
                bad++;
                $display("[TB] FAIL pixel_accept_timeout: got no accept want accept");
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        pixel_valid = 1'b0;
        pixel_last  = 1'b0;
        pixel_in    = 24'($urandom);
    endtask

    task automatic drainOutput(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL %s_drain_timeout: got %0d pending want 0", name, exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic sendFourKnown(input string name);
        int w;
        logic [23:0] px[4];
        px[0] = 24'h030201; px[1] = 24'h060504; px[2] = 24'h090807; px[3] = 24'h0C0B0A;
        got_data.delete();
        got_last.delete();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(px[i], i == 3, 0, w);
            checkOutput({name, "_no_wait"}, 32'(w), 32'd0);
        end
        drainOutput(name);
        checkOutput({name, "_count"}, 32'(got_data.size()), 32'd3);
        checkOutput({name, "_w0"}, got_data[0], 32'h04030201);
        checkOutput({name, "_w1"}, got_data[1], 32'h08070605);
        checkOutput({name, "_w2"}, got_data[2], 32'h0C0B0A09);
        checkOutput({name, "_last"}, {29'b0, got_last[0], got_last[1], got_last[2]}, 32'b001);
    endtask

    initial begin
        int w;
        int len;
        rst           = 1'b1;
        pixel_valid   = 1'b0;
        pixel_last    = 1'b0;
        pixel_in      = 24'h0;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
        checkOutput("reset_tlast", {31'b0, m_axis_tlast}, 32'd0);
        checkOutput("reset_tdata", m_axis_tdata, 32'd0);
        checkOutput("reset_pready", {31'b0, pixel_ready}, 32'd1);
`ifdef PIXEL_PACK_TKEEP_EN
        checkOutput("reset_tkeep", {28'b0, m_axis_tkeep}, 32'd0);
`endif
        @(posedge clk);
        #1;

        // Four known pixels make three words.
        sendFourKnown("s1");

        // Eight back-to-back pixels make six words.
        got_data.delete();
        got_last.delete();
        for (int i = 0; i < 8; i++) applyStimulus(24'($urandom), i == 7, 0, w);
        drainOutput("s2");
        checkOutput("s2_count", 32'(got_data.size()), 32'd6);

        // A single pixel is flushed with three bytes.
        got_data.delete();
        got_last.delete();
        applyStimulus(24'hAABBCC, 1'b1, 0, w);
        drainOutput("s3");
        checkOutput("s3_w0", got_data[0], 32'h00AABBCC);
        checkOutput("s3_last", {31'b0, got_last[0]}, 32'd1);

        // Two pixels give one full word and a two-byte flush.
        got_data.delete();
        got_last.delete();
        applyStimulus(24'h030201, 1'b0, 0, w);
        applyStimulus(24'h060504, 1'b1, 0, w);
        drainOutput("s4");
        checkOutput("s4_w0", got_data[0], 32'h04030201);
        checkOutput("s4_w1", got_data[1], 32'h00000605);
        checkOutput("s4_last", {30'b0, got_last[0], got_last[1]}, 32'b01);

        // Backpressure: hold tready low for five cycles while a word is pending.
        got_data.delete();
        got_last.delete();
        tready_mode   = 2;
        m_axis_tready = 1'b1;
        applyStimulus(24'h030201, 1'b0, 0, w);
        applyStimulus(24'h060504, 1'b0, 0, w);
        m_axis_tready = 1'b0;
        fork
            applyStimulus(24'h090807, 1'b0, 0, w);
            begin
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("s5_hold_tdata", m_axis_tdata, 32'h04030201);
                    checkOutput("s5_hold_pready", {31'b0, pixel_ready}, 32'd0);
                end
                @(posedge clk);
                #1;
                m_axis_tready = 1'b1;
            end
        join
        applyStimulus(24'h0C0B0A, 1'b1, 0, w);
        drainOutput("s5");
        tready_mode = 0;
        checkOutput("s5_count", 32'(got_data.size()), 32'd3);
        checkOutput("s5_w0", got_data[0], 32'h04030201);
        checkOutput("s5_w1", got_data[1], 32'h08070605);
        checkOutput("s5_w2", got_data[2], 32'h0C0B0A09);

        // Reset mid-packet, then repeat the known sequence.
        applyStimulus(24'h112233, 1'b0, 0, w);
        applyStimulus(24'h445566, 1'b0, 0, w);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("s6_tvalid_after_reset", {31'b0, m_axis_tvalid}, 32'd0);
        @(posedge clk);
        #1;
        sendFourKnown("s6");

        // Random packets with random gaps and random backpressure.
        tready_mode = 1;
        for (int pk = 0; pk < 40; pk++) begin
            len = $urandom_range(1, 9);
            for (int i = 0; i < len; i++)
                applyStimulus(24'($urandom), i == len - 1, $urandom_range(0, 2), w);
        end
        drainOutput("rand");
        tready_mode = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_to_m_axis_packer.md
Name: pixel_to_m_axis_packer

Overview:
Packs a stream of 24-bit RGB pixels into 32-bit AXI4-Stream master words, so that 4 pixels become 3 words with no gaps. It is the transmit-side counterpart of the 32-to-24 pixel unpacker. It sits at the output of the upsampling pipeline and feeds the VDMA/S2MM AXIS port. On frame/line end it flushes any partial word and marks it with TLAST.

Parameters:
C_M_AXIS_TDATA_WIDTH, 32, AXIS data width; only 32 is supported.
PIXEL_WIDTH, 24, pixel width; only 24 (3 bytes) is supported.

Ports:
clk  input  1  sole clock; everything is rising-edge
rst  input  1  synchronous, active-high reset
pixel_in  input  PIXEL_WIDTH  pixel, byte0 at [7:0]
pixel_valid  input  1  upstream pixel valid
pixel_ready  output  1  packer accepts pixel_in this cycle
pixel_last  input  1  marks the final pixel of the packet, qualified by pixel_valid
m_axis_tdata  output  C_M_AXIS_TDATA_WIDTH  packed word
m_axis_tvalid  output  1  word valid
m_axis_tready  input  1  downstream ready
m_axis_tlast  output  1  final word of the packet
m_axis_tkeep  output  4  byte enables; present only with PIXEL_PACK_TKEEP_EN

Behaviour:
- Byte order is little-endian, continuous. Stream bytes P0b0 P0b1 P0b2 P1b0 ... fill word bits [7:0], [15:8], and so on.
  - W0 = {P1[7:0], P0}
  - W1 = {P2[15:0], P1[23:8]}
  - W2 = {P3, P2[23:16]}
- Residue register: 24 bits. Phase counter: 2 bits, 0..3.
  - Phase = pixels accepted mod 4.
  - Residue bytes held after each phase: phase0→3, phase1→2, phase2→1, phase3→0.
- Accept = pixel_valid & pixel_ready.
- Output register is a single stage: tdata, tvalid, tlast (and tkeep).
  - It is "free" when !m_axis_tvalid | m_axis_tready.
- pixel_ready = free & (state == RUN). This is combinational from m_axis_tready.
- Accept in phase 0: residue <= pixel_in; no word is emitted; tvalid clears if the old word was taken.
- Accept in phases 1/2/3: load the output register with the word from residue plus pixel_in; tvalid <= 1; residue <= leftover bytes.
- Phase advances on every accept and wraps 3→0.
- Latency: a completing pixel appears on m_axis the cycle after acceptance.
- States are RUN and FLUSH.
  - Accept with pixel_last in phase 3: the word carries tlast=1; phase <= 0; stay in RUN.
  - Accept with pixel_last in phase 0, 1 or 2: there are leftover bytes.
    - Phase 0 case: no word is emitted now. Go to FLUSH, with 3 leftover bytes.
    - Phase 1/2 case: emit the current word with tlast=0, then go to FLUSH.
  - FLUSH: pixel_ready=0. When free, load the residue zero-padded in the upper bytes, with tlast=1. Then phase <= 0 and return to RUN.
- Words are held stable while tvalid & !tready. No word is ever dropped or duplicated.
- Reset: tvalid=0, tlast=0, tdata=0, tkeep=0, phase=0, residue=0, state=RUN. Reset mid-packet discards the partial residue.
- With tvalid=1 and tready=0, pixel_ready=0 in every phase, including phase 0. This keeps the accept logic uniform.

Optional Feature:
PIXEL_PACK_TKEEP_EN
- Defined: the m_axis_tkeep port exists.
  - Normal words: 4'b1111.
  - Flush words: 4'b0111 for 3 residue bytes, 4'b0011 for 2, 4'b0001 for 1.
  - Reset value: 4'b0000.
- Undefined: no tkeep port. Padding bytes are zero and the consumer infers length from the pixel count.

Test Plan:
- 4 pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A (last on 4th), tready=1 → words 0x04030201, 0x08070605, 0x0C0B0A09; tlast only on the third; pixel_ready stays 1.
- 8 pixels streamed back-to-back, tready=1 → 6 words; tvalid low exactly in the cycle after each phase-0 accept.
- 1 pixel 0xAABBCC with last → one word 0x00AABBCC, tlast=1, tkeep=0111 (TKEEP_EN); pixel_ready=0 during FLUSH.
- 2 pixels 0x030201, 0x060504 (last) → 0x04030201 (tlast=0), then 0x00000605 (tlast=1, tkeep=0011).
- tready held 0 for 5 cycles while a word is pending → tdata/tvalid/tlast stable, pixel_ready=0, no pixel consumed; on release the sequence continues correctly.
- Assert rst after 2 pixels, then send 4 fresh pixels → tvalid=0 the cycle after reset; the next words match the first scenario with no stale bytes.
